// File: rtl/pio_output_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO output port: word address, select,
// active-low write strobe, write data, and combinational read data.
interface pio_output_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_output_ctrl.sv
// Memory-mapped output port with bit set/clear/toggle, hardware one-shot pulses and pulse-done irq.
// Writes take effect on the write edge with no wait state; reads are combinational; never stalls the bus.
module pio_output_ctrl #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PULSE_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_output_ctrl_if.slave     bus,
    output logic [WIDTH-1:0]     out_port,
    output logic                 irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_PULSE  = 3'd4;
    localparam logic [2:0] ADDR_LEN    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam logic [PULSE_W-1:0] CNT_ONE = PULSE_W'(1);

    logic [WIDTH-1:0]   data_out;
    logic [WIDTH-1:0]   active;
    logic [PULSE_W-1:0] count;
    logic [PULSE_W-1:0] len;
    logic               done;
    logic               irq_en;

    logic [WIDTH-1:0]   data_nxt;
    logic [WIDTH-1:0]   active_nxt;
    logic [PULSE_W-1:0] count_nxt;
    logic [PULSE_W-1:0] len_nxt;
    logic               done_nxt;
    logic               irq_en_nxt;

    logic               wr;
    logic [WIDTH-1:0]   wd;
    logic [PULSE_W-1:0] len_eff;
    logic               expire;
    logic               busy;
    logic [31:0]        rdata;
    logic               unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign len_eff   = (len == '0) ? CNT_ONE : len;
    assign expire    = (count == CNT_ONE);
    assign busy      = (count != '0);
    assign unused_wd = ^bus.writedata;

    // Expiry is folded in first so a same-edge bus write sees the post-expiry state.
    always_comb begin
        data_nxt   = data_out;
        active_nxt = active;
        count_nxt  = count;
        len_nxt    = len;
        done_nxt   = done;
        irq_en_nxt = irq_en;

        if (expire) begin
            data_nxt   = data_out & ~active;
            active_nxt = '0;
            count_nxt  = '0;
            done_nxt   = 1'b1;
        end else if (busy) begin
            count_nxt  = count - CNT_ONE;
        end

        if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_nxt = wd;
                ADDR_SET:    data_nxt = data_nxt | wd;
                ADDR_CLEAR:  data_nxt = data_nxt & ~wd;
                ADDR_TOGGLE: data_nxt = data_nxt ^ wd;
                ADDR_PULSE: begin
                    if (wd != '0) begin
                        data_nxt   = data_nxt | wd;
                        active_nxt = active_nxt | wd;
                        count_nxt  = len_eff;
                    end
                end
                ADDR_LEN:    len_nxt = bus.writedata[PULSE_W-1:0];
                ADDR_STATUS: begin
                    irq_en_nxt = bus.writedata[2];
                    // A done being raised on this edge outranks the clear.
                    if (bus.writedata[1] && !expire) begin
                        done_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            active   <= '0;
            count    <= '0;
            len      <= CNT_ONE;
            done     <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            data_out <= data_nxt;
            active   <= active_nxt;
            count    <= count_nxt;
            len      <= len_nxt;
            done     <= done_nxt;
            irq_en   <= irq_en_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:   rdata[WIDTH-1:0]   = data_out;
            ADDR_PULSE:  rdata[WIDTH-1:0]   = active;
            ADDR_LEN:    rdata[PULSE_W-1:0] = len;
            ADDR_STATUS: rdata[2:0]         = {irq_en, done, busy};
            default:     rdata              = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign out_port     = data_out;
    assign irq          = done & irq_en;

endmodule

// File: tb/tb_pio_output_ctrl.sv
// Bench for pio_output_ctrl: constant-table vectors, directed pulse corner cases,
// and random traffic against a deadline-based model of the port.
module tb_pio_output_ctrl;

    localparam int unsigned      WIDTH   = 8;
    localparam logic [WIDTH-1:0] RST_VAL = 8'h5A;
    localparam int unsigned      PULSE_W = 16;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    pio_output_ctrl_if bus ();

    pio_output_ctrl #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RST_VAL),
        .PULSE_W     (PULSE_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a pulse is an absolute edge number at which it ends (0 = idle).
    logic [7:0]  m_data;
    logic [7:0]  m_active;
    int          m_len;
    bit          m_done;
    bit          m_irq_en;
    int          m_end;
    int          cyc;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_data   = RST_VAL;
        m_active = '0;
        m_len    = 1;
        m_done   = 0;
        m_irq_en = 0;
        m_end    = 0;
    endtask

    task automatic model_edge(input logic [2:0] addr, input bit we, input logic [31:0] wd);
        bit expired;
        cyc++;
        expired = 0;
        if (m_end != 0 && cyc == m_end) begin
            m_data   = m_data & ~m_active;
            m_active = '0;
            m_end    = 0;
            m_done   = 1;
            expired  = 1;
        end
        if (we) begin
            case (addr)
                3'd0: m_data = wd[7:0];
                3'd1: m_data = m_data | wd[7:0];
                3'd2: m_data = m_data & ~wd[7:0];
                3'd3: m_data = m_data ^ wd[7:0];
                3'd4: if (wd[7:0] != 0) begin
                    m_data   = m_data | wd[7:0];
                    m_active = m_active | wd[7:0];
                    m_end    = cyc + ((m_len == 0) ? 1 : m_len);
                end
                3'd5: m_len = int'(wd[15:0]);
                3'd6: begin
                    m_irq_en = wd[2];
                    if (wd[1] && !expired) m_done = 0;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] addr);
        logic [31:0] r;
        r = '0;
        case (addr)
            3'd0: r[7:0]  = m_data;
            3'd4: r[7:0]  = m_active;
            3'd5: r[15:0] = m_len[15:0];
            3'd6: r[2:0]  = {m_irq_en, m_done, (m_end != 0)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // One bus edge; afterwards out_port/irq and one read address are checked against the model.
    task automatic bus_cycle(input logic [2:0] addr, input bit cs, input bit wn,
                             input logic [31:0] wd, input logic [2:0] rd_addr);
        bus.address    = addr;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        @(posedge clk);
        model_edge(addr, cs && !wn, wd);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check("model_out_port", 32'(out_port), 32'(m_data));
        check("model_irq", 32'(irq), 32'(m_done & m_irq_en));
        bus.address = rd_addr;
        #1;
        check("model_readdata", bus.readdata, model_read(rd_addr));
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd, input logic [2:0] rd_addr);
        bus_cycle(addr, 1'b1, 1'b0, wd, rd_addr);
    endtask

    task automatic idle(input logic [2:0] rd_addr);
        bus_cycle(3'd7, 1'b0, 1'b1, 32'h0, rd_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        tbl[0] = '{3'd0, 32'h0000_01FF, 8'hFF, 3'd0, 32'h0000_00FF};
        tbl[1] = '{3'd0, 32'h0000_000F, 8'h0F, 3'd1, 32'h0};
        tbl[2] = '{3'd1, 32'h0000_0030, 8'h3F, 3'd2, 32'h0};
        tbl[3] = '{3'd2, 32'h0000_0003, 8'h3C, 3'd3, 32'h0};
        tbl[4] = '{3'd3, 32'h0000_00FF, 8'hC3, 3'd0, 32'h0000_00C3};
        tbl[5] = '{3'd5, 32'h0000_0000, 8'hC3, 3'd5, 32'h0};
        tbl[6] = '{3'd5, 32'h0000_0005, 8'hC3, 3'd5, 32'h5};
        tbl[7] = '{3'd6, 32'h0000_0004, 8'hC3, 3'd6, 32'h4};
        tbl[8] = '{3'd0, 32'h0000_0000, 8'h00, 3'd7, 32'h0};
        tbl[9] = '{3'd7, 32'h0000_00FF, 8'h00, 3'd7, 32'h0};

        cyc            = 0;
        reset_n        = 1'b0;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_reset();
        #12;
        reset_n = 1'b1;
        #1;
        check("rst_out_port", 32'(out_port), 32'h5A);
        check("rst_read_data", bus.readdata, 32'h5A);
        check("rst_irq", 32'(irq), 32'h0);
        bus.address = 3'd5; #1;
        check("rst_len", bus.readdata, 32'h1);
        bus.address = 3'd6; #1;
        check("rst_status", bus.readdata, 32'h0);

        foreach (tbl[i]) begin
            wr(tbl[i].addr, tbl[i].wd, tbl[i].rd_addr);
            check($sformatf("tbl%0d_out", i), 32'(out_port), 32'(tbl[i].exp_out));
            check($sformatf("tbl%0d_rd", i), bus.readdata, tbl[i].exp_rd);
        end

        // Pulse of length 5 with irq enabled.
        wr(3'd4, 32'h01, 3'd6);
        check("pulse_busy", 32'(bus.readdata[0]), 32'h1);
        hi = 1;
        for (int i = 0; i < 20 && out_port[0]; i++) begin
            idle(3'd6);
            if (out_port[0]) hi++;
        end
        check("pulse_len5", hi, 5);
        check("pulse_irq", 32'(irq), 32'h1);
        check("pulse_status_done", bus.readdata, 32'h6);
        wr(3'd6, 32'h6, 3'd6);
        check("clear_done_irq", 32'(irq), 32'h0);
        check("clear_done_status", bus.readdata, 32'h4);

        // LEN=0 behaves as 1, then merged pulses share the reloaded length.
        wr(3'd5, 32'h0, 3'd5);
        wr(3'd4, 32'h02, 3'd0);
        check("len0_high", 32'(out_port), 32'h02);
        idle(3'd0);
        check("len0_low", 32'(out_port), 32'h00);
        wr(3'd5, 32'd10, 3'd5);
        wr(3'd4, 32'h01, 3'd4);
        for (int i = 0; i < 3; i++) idle(3'd4);
        wr(3'd4, 32'h04, 3'd4);
        check("merge_active_read", bus.readdata, 32'h05);
        hi = 1;
        for (int i = 0; i < 30 && out_port[2]; i++) begin
            idle(3'd4);
            if (out_port[2] && out_port[0]) hi++;
        end
        check("merge_len10", hi, 10);
        check("merge_cleared", 32'(out_port), 32'h0);

        // Same-edge collisions with expiry, LEN=3.
        wr(3'd5, 32'd3, 3'd5);
        wr(3'd6, 32'h6, 3'd6);
        wr(3'd4, 32'h01, 3'd0);
        idle(3'd0); idle(3'd0);
        wr(3'd1, 32'h80, 3'd0);
        check("coll_set_out", 32'(out_port), 32'h80);
        wr(3'd6, 32'h6, 3'd6);
        check("coll_pre_status", bus.readdata, 32'h4);
        wr(3'd4, 32'h01, 3'd6);
        idle(3'd6); idle(3'd6);
        wr(3'd6, 32'h6, 3'd6);
        check("coll_done_wins", bus.readdata, 32'h6);
        check("coll_done_irq", 32'(irq), 32'h1);
        wr(3'd4, 32'h01, 3'd4);
        idle(3'd4); idle(3'd4);
        wr(3'd4, 32'h02, 3'd4);
        check("coll_relaunch_out", 32'(out_port), 32'h82);
        check("coll_relaunch_active", bus.readdata, 32'h02);
        hi = 1;
        for (int i = 0; i < 20 && out_port[1]; i++) begin
            idle(3'd4);
            if (out_port[1]) hi++;
        end
        check("coll_relaunch_len", hi, 3);

        // Reset while count is 3.
        wr(3'd5, 32'd5, 3'd5);
        wr(3'd4, 32'h01, 3'd0);
        idle(3'd0); idle(3'd0);
        reset_n = 1'b0;
        bus.address = 3'd6;
        #1;
        model_reset();
        check("midrst_out", 32'(out_port), 32'h5A);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_status", bus.readdata, 32'h0);
        #3;
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd5) d = $urandom_range(0, 6);
            if (a == 3'd4 && $urandom_range(0, 3) == 0) d[7:0] = 8'h00;
            bus_cycle(a, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, d,
                      3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
